// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
//   Shared definitions for the pipeline stall/flush sequencer:
//   - multiply FSM state encodings
//   - the hard-wired zero register index
//   - the packed control bundle driven to the pipeline registers
// ----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic pc_redirect;
        logic mul_start;
    } pipe_ctl_t;

    // Everything parked: used for reset, global disable and as a default.
    function automatic pipe_ctl_t ctl_idle();
        pipe_ctl_t c;
        c = '0;
        return c;
    endfunction

    // Normal advance: every register loads, nothing is cleared.
    function automatic pipe_ctl_t ctl_run();
        pipe_ctl_t c;
        c           = '0;
        c.pc_en     = 1'b1;
        c.if_id_en  = 1'b1;
        c.id_ex_en  = 1'b1;
        c.ex_mem_en = 1'b1;
        c.mem_wb_en = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_raw_hazard_detect.sv
// ----------------------------------------------------------------------------
// raw_hazard_detect
//   Combinational RAW check for a datapath without forwarding. The instruction
//   in ID must wait while any older instruction in EX, MEM (and WB when the
//   register file is not write-through) will write one of its sources.
//
//   Ports
//     rs1_ID, rs2_ID       in  source indices of the ID instruction
//     use_rs1, use_rs2     in  ID instruction really reads that source
//     rd_EX/MEM/WB         in  destination index per stage
//     wr_EX/MEM/WB         in  reg_write per stage
//     raw                  out a source matches a pending write
// ----------------------------------------------------------------------------
module raw_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter bit RF_WT = 1'b0
) (
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic       use_rs1,
    input  logic       use_rs2,
    input  logic [4:0] rd_EX,
    input  logic [4:0] rd_MEM,
    input  logic [4:0] rd_WB,
    input  logic       wr_EX,
    input  logic       wr_MEM,
    input  logic       wr_WB,
    output logic       raw
);

    // x0 writes are architectural no-ops and never create a dependency.
    function automatic logic src_match(input logic [4:0] rd, input logic wr);
        logic live;
        live = wr && (rd != REG_X0);
        return live && ((use_rs1 && (rs1_ID == rd)) || (use_rs2 && (rs2_ID == rd)));
    endfunction

    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    always_comb begin
        hit_ex  = src_match(rd_EX, wr_EX);
        hit_mem = src_match(rd_MEM, wr_MEM);
        // A write-through register file returns the WB value in the same cycle.
        hit_wb  = RF_WT ? 1'b0 : src_match(rd_WB, wr_WB);
        raw     = hit_ex || hit_mem || hit_wb;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the 5-stage RV64 pipeline. Produces load enables
//   and synchronous clears for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, the PC
//   redirect, and launches / tracks the fixed-latency multiplier in EX.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no multiply in flight; a mul in EX launches here
//   BUSY  | multiplier running, front end frozen, EX/MEM bubbled
//   DONE  | product valid, pipeline advances normally, back to IDLE
//
//   Ports
//     clk, arst_n              clock, synchronous active-low reset
//     enable                   global run; 0 parks every control output
//     rs1_ID..wr_WB            hazard inputs (see raw_hazard_detect)
//     mul_EX                   instruction in EX is a multiply
//     branch_MEM, zero_MEM     branch resolved in MEM and its condition
//     jump_MEM                 jump in MEM
//     pc_en..mem_wb_en         register load enables
//     if_id_flush..ex_mem_flush bubble insert at the next edge
//     pc_redirect              PC takes the branch/jump target
//     mul_start                one-cycle multiplier launch
//     mul_busy                 FSM not in IDLE
//     stall_cnt, flush_cnt     saturating event counters
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 32,
    parameter bit RF_WT   = 1'b0
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             enable,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic [4:0]       rd_EX,
    input  logic [4:0]       rd_MEM,
    input  logic [4:0]       rd_WB,
    input  logic             wr_EX,
    input  logic             wr_MEM,
    input  logic             wr_WB,
    input  logic             mul_EX,
    input  logic             branch_MEM,
    input  logic             zero_MEM,
    input  logic             jump_MEM,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pc_redirect,
    output logic             mul_start,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // cnt only has to hold MUL_LAT-1.
    localparam int LAT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [LAT_W-1:0] cnt;
    logic [LAT_W-1:0] cnt_nxt;

    logic       raw;
    logic       redirect;
    logic       start;
    logic       mul_stall;
    logic       raw_stall;
    logic       stall_evt;
    pipe_ctl_t  ctl;

    raw_hazard_detect #(
        .RF_WT (RF_WT)
    ) u_raw (
        .rs1_ID  (rs1_ID),
        .rs2_ID  (rs2_ID),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2),
        .rd_EX   (rd_EX),
        .rd_MEM  (rd_MEM),
        .rd_WB   (rd_WB),
        .wr_EX   (wr_EX),
        .wr_MEM  (wr_MEM),
        .wr_WB   (wr_WB),
        .raw     (raw)
    );

    // Priority: redirect > multiply stall > RAW stall > run.
    always_comb begin
        redirect  = (branch_MEM && zero_MEM) || jump_MEM;
        start     = (state == ST_IDLE) && mul_EX && !redirect;
        mul_stall = start || ((state == ST_BUSY) && !redirect);
        raw_stall = raw && !redirect && !mul_stall;
        stall_evt = mul_stall || raw_stall;
    end

    always_comb begin
        ctl = ctl_idle();
        if (arst_n && enable) begin
            if (redirect) begin
                ctl              = ctl_run();
                ctl.if_id_flush  = 1'b1;
                ctl.id_ex_flush  = 1'b1;
                ctl.ex_mem_flush = 1'b1;
                ctl.pc_redirect  = 1'b1;
            end else if (mul_stall) begin
                // The mul stays in ID/EX; EX/MEM receives bubbles behind it.
                ctl              = ctl_idle();
                ctl.ex_mem_en    = 1'b1;
                ctl.ex_mem_flush = 1'b1;
                ctl.mem_wb_en    = 1'b1;
                ctl.mul_start    = start;
            end else if (raw_stall) begin
                // Hold PC and IF/ID, push a bubble into EX, let producers drain.
                ctl             = ctl_run();
                ctl.pc_en       = 1'b0;
                ctl.if_id_en    = 1'b0;
                ctl.id_ex_flush = 1'b1;
            end else begin
                ctl = ctl_run();
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (redirect) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (MUL_LAT == 1) begin
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt = ST_BUSY;
                            cnt_nxt   = LAT_W'(MUL_LAT - 1);
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == LAT_W'(1)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_nxt = cnt - LAT_W'(1);
                    end
                end
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (enable) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (stall_evt && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        pc_en        = ctl.pc_en;
        if_id_en     = ctl.if_id_en;
        id_ex_en     = ctl.id_ex_en;
        ex_mem_en    = ctl.ex_mem_en;
        mem_wb_en    = ctl.mem_wb_en;
        if_id_flush  = ctl.if_id_flush;
        id_ex_flush  = ctl.id_ex_flush;
        ex_mem_flush = ctl.ex_mem_flush;
        pc_redirect  = ctl.pc_redirect;
        mul_start    = ctl.mul_start;
        mul_busy     = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int MUL_LAT = 2;
    localparam int CNT_W   = 5;
    localparam bit RF_WT   = 1'b0;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic             enable = 1'b0;
    logic [4:0]       rs1_ID = '0, rs2_ID = '0;
    logic             use_rs1 = 1'b0, use_rs2 = 1'b0;
    logic [4:0]       rd_EX = '0, rd_MEM = '0, rd_WB = '0;
    logic             wr_EX = 1'b0, wr_MEM = 1'b0, wr_WB = 1'b0;
    logic             mul_EX = 1'b0, branch_MEM = 1'b0, zero_MEM = 1'b0, jump_MEM = 1'b0;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush;
    logic             pc_redirect, mul_start, mul_busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W), .RF_WT(RF_WT)) dut (
        .clk(clk), .arst_n(arst_n), .enable(enable),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .rd_EX(rd_EX), .rd_MEM(rd_MEM), .rd_WB(rd_WB),
        .wr_EX(wr_EX), .wr_MEM(wr_MEM), .wr_WB(wr_WB),
        .mul_EX(mul_EX), .branch_MEM(branch_MEM), .zero_MEM(zero_MEM), .jump_MEM(jump_MEM),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .pc_redirect(pc_redirect), .mul_start(mul_start),
        .mul_busy(mul_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    //  if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect, mul_start, mul_busy}
    typedef struct {
        logic [10:0] ctl;
        int          sc;
        int          fc;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   issued     = 0;

    // Reference model: multiply tracked as "stall cycles still owed" plus a
    // one-cycle "product ready" marker; counters as plain integers.
    int m_owed = 0;
    bit m_ready = 1'b0;
    int m_sc = 0;
    int m_fc = 0;

    function automatic bit reads(input logic [4:0] rd, input logic wr);
        if (!wr || rd == 5'd0) return 1'b0;
        return (use_rs1 && rs1_ID == rd) || (use_rs2 && rs2_ID == rd);
    endfunction

    task automatic apply(input bit rn, input bit en,
                         input logic [4:0] s1, input logic [4:0] s2, input bit u1, input bit u2,
                         input logic [4:0] de, input logic [4:0] dm, input logic [4:0] dw,
                         input bit we, input bit wm, input bit ww,
                         input bit mul, input bit br, input bit z, input bit j);
        exp_t e;
        bit   redir, dep, idle, mstall, rstall;
        @(posedge clk);
        #1;
        arst_n = rn; enable = en;
        rs1_ID = s1; rs2_ID = s2; use_rs1 = u1; use_rs2 = u2;
        rd_EX = de; rd_MEM = dm; rd_WB = dw; wr_EX = we; wr_MEM = wm; wr_WB = ww;
        mul_EX = mul; branch_MEM = br; zero_MEM = z; jump_MEM = j;

        redir  = (br && z) || j;
        dep    = reads(de, we) || reads(dm, wm) || (!RF_WT && reads(dw, ww));
        idle   = (m_owed == 0) && !m_ready;
        mstall = !redir && ((idle && mul) || m_owed > 0);
        rstall = !redir && !mstall && dep;

        e.sc  = m_sc;
        e.fc  = m_fc;
        e.idx = issued;
        e.ctl = {10'b0, !idle};
        if (rn && en) begin
            if (redir)       e.ctl[10:1] = 10'b11111_11110;
            else if (mstall) e.ctl[10:1] = {5'b00011, 3'b001, 1'b0, idle};
            else if (rstall) e.ctl[10:1] = 10'b00111_01000;
            else             e.ctl[10:1] = 10'b11111_00000;
        end
        exp_q.push_back(e);
        issued++;

        if (!rn) begin
            m_owed = 0; m_ready = 1'b0; m_sc = 0; m_fc = 0;
        end else if (en) begin
            if (mstall || rstall) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
            if (redir)            m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
            if (redir) begin
                m_owed = 0; m_ready = 1'b0;
            end else if (idle && mul) begin
                m_owed  = MUL_LAT - 1;
                m_ready = (m_owed == 0);
            end else if (m_owed > 0) begin
                m_owed  = m_owed - 1;
                m_ready = (m_owed == 0);
            end else begin
                m_ready = 1'b0;
            end
        end
    endtask

    task automatic quiet(input bit rn, input bit en, input bit mul);
        apply(rn, en, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, mul, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [10:0] act;
            e   = exp_q.pop_front();
            act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect, mul_start, mul_busy};
            vectors++;
            if (act !== e.ctl || stall_cnt !== CNT_W'(e.sc) || flush_cnt !== CNT_W'(e.fc)) begin
                miscompares++;
                $display("FAIL vec%0d ctl act=%b exp=%b stall_cnt act=%0d exp=%0d flush_cnt act=%0d exp=%0d",
                         e.idx, act, e.ctl, stall_cnt, e.sc, flush_cnt, e.fc);
            end
        end
    end

    initial begin
        int wait_cyc;
        // Establish reset before anything is checked.
        @(posedge clk); @(posedge clk);
        quiet(1'b0, 1'b1, 1'b0);

        // add x5 in EX, dependent in ID: EX, MEM, WB matches then free.
        apply(1,1, 5'd5,5'd0,1,0, 5'd5,5'd0,5'd0, 1,0,0, 0,0,0,0);
        apply(1,1, 5'd5,5'd0,1,0, 5'd0,5'd5,5'd0, 0,1,0, 0,0,0,0);
        apply(1,1, 5'd5,5'd0,1,0, 5'd0,5'd0,5'd5, 0,0,1, 0,0,0,0);
        apply(1,1, 5'd5,5'd0,1,0, 5'd0,5'd0,5'd0, 0,0,0, 0,0,0,0);
        // mul: start, busy, done, then normal.
        quiet(1,1,1); quiet(1,1,1); quiet(1,1,1); quiet(1,1,0);
        // beq taken, beq not taken.
        apply(1,1, 0,0,0,0, 0,0,0, 0,0,0, 0,1,1,0);
        apply(1,1, 0,0,0,0, 0,0,0, 0,0,0, 0,1,0,0);
        // mul entering EX with a jump in MEM.
        apply(1,1, 0,0,0,0, 0,0,0, 0,0,0, 1,0,0,1);
        quiet(1,1,0);
        // enable low for 4 cycles in BUSY, then finish.
        quiet(1,1,1);
        repeat (4) quiet(1,0,1);
        quiet(1,1,1); quiet(1,1,1); quiet(1,1,0);
        // x0 destination with write enable: no stall.
        apply(1,1, 5'd0,5'd0,1,1, 5'd0,5'd0,5'd0, 1,1,1, 0,0,0,0);
        // reset mid-BUSY.
        quiet(1,1,1); quiet(0,1,1); quiet(1,1,0);

        // Randomized traffic over a small register range for frequent hits.
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom % 500) != 0, ($urandom % 8) != 0,
                  5'($urandom % 4), 5'($urandom % 4), 1'($urandom), 1'($urandom),
                  5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom % 5) == 0, ($urandom % 8) == 0, 1'($urandom), ($urandom % 14) == 0);
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain pending act=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
